// File: rtl/led_duty_sequencer.sv
// Duty-cycle table for the PWM LED bank: loads a saturated ramp, then rotates it
// one slot per step interval, committed only at PWM period boundaries.
// Optional ping-pong motion is built when LED_SEQ_BOUNCE_EN is defined.
module led_duty_sequencer #(
  parameter int N_LEDS     = 10,
  parameter int DUTY_W     = 7,
  parameter int DUTY_STEP  = 10,
  parameter int DUTY_MAX   = 99,
  parameter int STEP_TICKS = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sentido,
  input  logic                     restart,
  input  logic                     period_start,
  output logic [N_LEDS*DUTY_W-1:0] duty_out,
  output logic                     ready,
  output logic                     step_pulse,
  output logic [3:0]               pos
);

  localparam int                CNT_W     = $clog2(STEP_TICKS);
  localparam int                RAMP_W    = DUTY_W + 4;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [3:0]        POS_LAST  = 4'(N_LEDS - 1);
  localparam logic [RAMP_W-1:0] RAMP_STEP = RAMP_W'(DUTY_STEP);
  localparam logic [RAMP_W-1:0] RAMP_MAX  = RAMP_W'(DUTY_MAX);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         idx;
  logic [CNT_W-1:0]   cnt;
  logic               pending;
  logic [DUTY_W-1:0]  duty [N_LEDS];

  logic               wrap;
  logic               rotate;
  logic               init_done;
  logic               rot_dir;
  logic [3:0]         pos_inc;
  logic [3:0]         pos_dec;
  logic [RAMP_W-1:0]  ramp;
  logic [DUTY_W-1:0]  ramp_sat;

  // period_start and step_pulse are single-cycle strobes with no back-pressure:
  // a rotation is committed on the edge where period_start meets a due step,
  // and step_pulse marks the first cycle the rotated table is visible.
  always_comb begin
    wrap      = (state == ST_RUN) && enable && (cnt == CNT_LAST);
    rotate    = (state == ST_RUN) && period_start && (pending || wrap);
    init_done = (state == ST_INIT) && (idx == POS_LAST);
    ramp      = RAMP_W'(idx) * RAMP_STEP;
    ramp_sat  = (ramp > RAMP_MAX) ? DUTY_W'(DUTY_MAX) : ramp[DUTY_W-1:0];
    pos_inc   = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
    pos_dec   = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
  end

`ifdef LED_SEQ_BOUNCE_EN
  logic dir;

  assign rot_dir = dir;

  // Direction is latched on entry to RUN and flips at either end of the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= 1'b0;
    end else if (!restart) begin
      if (init_done) begin
        dir <= sentido;
      end else if (rotate) begin
        if (!dir && (pos_inc == POS_LAST)) begin
          dir <= 1'b1;
        end else if (dir && (pos_dec == 4'd0)) begin
          dir <= 1'b0;
        end
      end
    end
  end
`else
  assign rot_dir = sentido;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_done) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
    if (restart) state_nxt = ST_INIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 4'd0;
      cnt        <= '0;
      pending    <= 1'b0;
      pos        <= 4'd0;
      step_pulse <= 1'b0;
      for (int k = 0; k < N_LEDS; k++) duty[k] <= '0;
    end else begin
      step_pulse <= 1'b0;
      if (restart) begin
        // Table is left alone; the reload overwrites it one entry per cycle.
        idx     <= 4'd0;
        cnt     <= '0;
        pending <= 1'b0;
        pos     <= 4'd0;
      end else if (state == ST_INIT) begin
        for (int k = 0; k < N_LEDS; k++) begin
          if (idx == 4'(k)) duty[k] <= ramp_sat;
        end
        idx <= init_done ? 4'd0 : idx + 4'd1;
      end else begin
        if (enable) cnt <= wrap ? '0 : cnt + CNT_W'(1);
        if (rotate) begin
          pending    <= 1'b0;
          step_pulse <= 1'b1;
          if (!rot_dir) begin
            for (int k = 0; k < N_LEDS - 1; k++) duty[k] <= duty[k+1];
            duty[N_LEDS-1] <= duty[0];
            pos <= pos_inc;
          end else begin
            for (int k = 1; k < N_LEDS; k++) duty[k] <= duty[k-1];
            duty[0] <= duty[N_LEDS-1];
            pos <= pos_dec;
          end
        end else if (wrap) begin
          pending <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    duty_out = '0;
    for (int k = 0; k < N_LEDS; k++) duty_out[k*DUTY_W +: DUTY_W] = duty[k];
    ready = (state == ST_RUN);
  end

endmodule

// File: tb/tb_led_duty_sequencer.sv
// Bench for led_duty_sequencer: directed vector table, randomized traffic against
// a queue-based reference model, and a ping-pong sequence when LED_SEQ_BOUNCE_EN is set.
module tb_led_duty_sequencer;

  localparam int N     = 10;
  localparam int DW    = 7;
  localparam int DSTEP = 10;
  localparam int DMAX  = 99;
  localparam int TICKS = 4;
  localparam int W     = N * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         sentido;
  logic         restart;
  logic         period_start;
  logic [W-1:0] duty_out;
  logic         ready;
  logic         step_pulse;
  logic [3:0]   pos;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  led_duty_sequencer #(
    .N_LEDS(N), .DUTY_W(DW), .DUTY_STEP(DSTEP), .DUTY_MAX(DMAX), .STEP_TICKS(TICKS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sentido(sentido), .restart(restart),
    .period_start(period_start), .duty_out(duty_out), .ready(ready),
    .step_pulse(step_pulse), .pos(pos)
  );

  // ---------------- reference model ----------------
  bit m_run;
  int m_idx;
  int m_cnt;
  int m_pos;
  bit m_pending;
  bit m_step;
  bit m_dir;
  int m_duty[$];

  function automatic int ramp(int i);
    return (i * DSTEP > DMAX) ? DMAX : i * DSTEP;
  endfunction

  function automatic logic [W-1:0] model_pack();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(m_duty[k]);
    return v;
  endfunction

  task automatic model_clock(bit r, bit rs, bit en, bit sen, bit ps);
    bit wrap;
    bit rot;
    bit d;
    if (r) begin
      m_run = 0; m_idx = 0; m_cnt = 0; m_pending = 0; m_pos = 0; m_step = 0; m_dir = 0;
      for (int k = 0; k < N; k++) m_duty[k] = 0;
      return;
    end
    m_step = 0;
    if (rs) begin
      m_run = 0; m_idx = 0; m_pos = 0; m_pending = 0; m_cnt = 0;
      return;
    end
    if (!m_run) begin
      m_duty[m_idx] = ramp(m_idx);
      if (m_idx == N - 1) begin
        m_run = 1; m_idx = 0; m_dir = sen;
      end else begin
        m_idx++;
      end
      return;
    end
    wrap = en && (m_cnt == TICKS - 1);
    if (en) m_cnt = (m_cnt + 1) % TICKS;
    rot = ps && (m_pending || wrap);
`ifdef LED_SEQ_BOUNCE_EN
    d = m_dir;
`else
    d = sen;
`endif
    if (rot) begin
      m_step = 1;
      m_pending = 0;
      if (!d) begin
        m_duty.push_back(m_duty.pop_front());
        m_pos = (m_pos + 1) % N;
      end else begin
        m_duty.push_front(m_duty.pop_back());
        m_pos = (m_pos + N - 1) % N;
      end
`ifdef LED_SEQ_BOUNCE_EN
      if (!m_dir && m_pos == N - 1) m_dir = 1;
      else if (m_dir && m_pos == 0) m_dir = 0;
`endif
    end else if (wrap) begin
      m_pending = 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(string tag);
    check({tag, "/ready"}, 128'(ready), 128'(m_run));
    check({tag, "/step_pulse"}, 128'(step_pulse), 128'(m_step));
    check({tag, "/pos"}, 128'(pos), 128'(m_pos));
    check({tag, "/duty_out"}, 128'(duty_out), 128'(model_pack()));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(bit rs, bit en, bit sen, bit ps);
    restart      = rs;
    enable       = en;
    sentido      = sen;
    period_start = ps;
    @(posedge clk);
    model_clock(rst, rs, en, sen, ps);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit rs, en, sen, ps;
    bit e_ready, e_step;
    int e_pos, e_d0, e_d9;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int n, bit rs, bit en, bit sen, bit ps,
                     bit rdy, bit stp, int p, int d0, int d9);
    vec_t v;
    v.rs = rs; v.en = en; v.sen = sen; v.ps = ps;
    v.e_ready = rdy; v.e_step = stp; v.e_pos = p; v.e_d0 = d0; v.e_d9 = d9;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] got;
    for (int k = 0; k < N; k++) m_duty.push_back(0);
    rst = 1'b1; restart = 1'b0; enable = 1'b0; sentido = 1'b0; period_start = 1'b0;
    repeat (2) cycle(0, 0, 0, 0);
    check("reset/duty_out", 128'(duty_out), 128'(0));
    check("reset/ready", 128'(ready), 128'(0));
    check("reset/step_pulse", 128'(step_pulse), 128'(0));
    check("reset/pos", 128'(pos), 128'(0));
    rst = 1'b0;

`ifndef LED_SEQ_BOUNCE_EN
    //   n  rs en sen ps  rdy stp pos d0  d9
    add(9,  0, 0, 0, 0,  0,  0,  0,  0,  0);   // ramp load
    add(1,  0, 0, 0, 0,  1,  0,  0,  0, 90);   // tenth entry -> RUN
    add(4,  0, 1, 0, 0,  1,  0,  0,  0, 90);   // count to first wrap
    add(1,  0, 1, 0, 1,  1,  1,  1, 10,  0);   // pending applied, left
    add(2,  0, 1, 0, 0,  1,  0,  1, 10,  0);
    add(1,  0, 1, 1, 1,  1,  1,  0,  0, 90);   // wrap + period_start, right
    add(8,  0, 1, 0, 0,  1,  0,  0,  0, 90);   // two wraps, no boundary
    add(1,  0, 0, 0, 1,  1,  1,  1, 10,  0);   // one rotation, enable low
    add(1,  0, 0, 0, 1,  1,  0,  1, 10,  0);   // extra step was dropped
    add(4,  0, 1, 0, 0,  1,  0,  1, 10,  0);   // pending again
    add(1,  1, 1, 0, 1,  0,  0,  0, 10,  0);   // restart beats rotation
    add(6,  0, 1, 0, 0,  0,  0,  0,  0,  0);   // reload
    add(1,  0, 1, 0, 1,  0,  0,  0,  0,  0);   // period_start ignored in INIT
    add(2,  0, 1, 0, 0,  0,  0,  0,  0,  0);
    add(1,  0, 1, 0, 0,  1,  0,  0,  0, 90);
    add(3,  0, 0, 0, 1,  1,  0,  0,  0, 90);   // pending was cleared
    add(3,  0, 1, 0, 0,  1,  0,  0,  0, 90);
    add(1,  0, 1, 1, 1,  1,  1,  9, 90, 80);   // fresh ramp, right
    add(1,  0, 0, 0, 0,  1,  0,  9, 90, 80);

    foreach (tbl[i]) begin
      cycle(tbl[i].rs, tbl[i].en, tbl[i].sen, tbl[i].ps);
      check($sformatf("vec%0d/ready", i), 128'(ready), 128'(tbl[i].e_ready));
      check($sformatf("vec%0d/step_pulse", i), 128'(step_pulse), 128'(tbl[i].e_step));
      check($sformatf("vec%0d/pos", i), 128'(pos), 128'(tbl[i].e_pos));
      check($sformatf("vec%0d/d0", i), 128'(duty_out[0 +: DW]), 128'(tbl[i].e_d0));
      check($sformatf("vec%0d/d9", i), 128'(duty_out[9*DW +: DW]), 128'(tbl[i].e_d9));
      compare_model($sformatf("vec%0d", i));
      if (i == 9) begin
        for (int k = 0; k < N; k++)
          check($sformatf("ramp%0d", k), 128'(duty_out[k*DW +: DW]), 128'(ramp(k)));
      end
    end
`else
    for (int p = 1; p <= N - 1; p++) exp_q.push_back(W'(p));
    for (int p = N - 2; p >= 0; p--) exp_q.push_back(W'(p));
    repeat (N) cycle(0, 0, 0, 0);
    check("bounce/ready", 128'(ready), 128'(1));
    for (int r = 0; r < 2 * (N - 1); r++) begin
      repeat (TICKS - 1) begin
        cycle(0, 1, 1'($urandom_range(0, 1)), 0);
        compare_model("bounce");
      end
      cycle(0, 1, 1'($urandom_range(0, 1)), 1);
      check($sformatf("bounce%0d/step_pulse", r), 128'(step_pulse), 128'(1));
      got = exp_q.pop_front();
      check($sformatf("bounce%0d/pos", r), 128'(pos), 128'(got));
      compare_model("bounce");
    end
`endif

    // Randomized traffic; every committed rotation is also tracked in exp_q.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      if (m_step) exp_q.push_back(model_pack());
      compare_model("rand");
      if (step_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rand/unexpected_step", 128'(1), 128'(0));
        end else begin
          got = exp_q.pop_front();
          check("rand/rotated_table", 128'(duty_out), 128'(got));
        end
      end
    end
    rst = 1'b0;
    check("rand/scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
